// File: rtl/rmw_accumulation_buffer.sv
// rmw_accumulation_buffer: two-bank lane-wise read-modify-write accumulator with drain port (ACCUM_SATURATE_EN selects saturating adds)
module ram_sync_1r1w #(
  parameter int WIDTH = 64,
  parameter int AW = 7,
  parameter int DEPTH = 128
) (
  input  logic             clk,
  input  logic             re,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] rd,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end
endmodule

module rmw_accumulation_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES = 4,
  parameter int BANK_ADDR_WIDTH = 7,
  parameter int BANK_DEPTH = 128
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          switch_banks,
  input  logic                          acc_en,
  input  logic                          acc_clear,
  input  logic [BANK_ADDR_WIDTH-1:0]    acc_adr,
  input  logic [LANES*DATA_WIDTH-1:0]   acc_data,
  input  logic                          ren_wb,
  input  logic [BANK_ADDR_WIDTH-1:0]    radr_wb,
  output logic [LANES*DATA_WIDTH-1:0]   rdata_wb,
  output logic                          rvalid_wb,
  output logic                          busy,
  output logic                          active_bank
);
  localparam int W = LANES * DATA_WIDTH;
  logic ab, s2_v, s2_clr, s2_bank, p_v, p_bank, dr_v, dr_bank;
  logic [BANK_ADDR_WIDTH-1:0] s2_adr, p_adr;
  logic [W-1:0] s2_data, p_data, old, res;
  logic [W-1:0] q [2];
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic acc_side;
    assign acc_side = (ab == 1'(b));
    ram_sync_1r1w #(.WIDTH(W), .AW(BANK_ADDR_WIDTH), .DEPTH(BANK_DEPTH)) u_ram (
      .clk(clk),
      .re(acc_side ? acc_en : ren_wb),
      .ra(acc_side ? acc_adr : radr_wb),
      .rd(q[b]),
      .we(s2_v && rst_n && s2_bank == 1'(b)),
      .wa(s2_adr),
      .wd(res)
    );
  end
  // The SRAM read issued alongside P's write is stale, so P's result wins
  assign old = (p_v && p_adr == s2_adr && p_bank == s2_bank) ? p_data : q[s2_bank];
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DATA_WIDTH-1:0] a, d, s, r;
    assign a = old[l*DATA_WIDTH +: DATA_WIDTH];
    assign d = s2_data[l*DATA_WIDTH +: DATA_WIDTH];
    assign s = a + d;
`ifdef ACCUM_SATURATE_EN
    assign r = (a[DATA_WIDTH-1] == d[DATA_WIDTH-1] && s[DATA_WIDTH-1] != a[DATA_WIDTH-1])
             ? (a[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}})
             : s;
`else
    assign r = s;
`endif
    assign res[l*DATA_WIDTH +: DATA_WIDTH] = s2_clr ? d : r;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ab <= 1'b0;
      s2_v <= 1'b0;
      p_v <= 1'b0;
      dr_v <= 1'b0;
    end else begin
      ab <= ab ^ switch_banks;
      s2_v <= acc_en;
      p_v <= s2_v;
      dr_v <= ren_wb;
    end
  end
  always_ff @(posedge clk) begin
    s2_clr <= acc_clear;
    s2_adr <= acc_adr;
    s2_data <= acc_data;
    s2_bank <= ab;
    p_adr <= s2_adr;
    p_bank <= s2_bank;
    p_data <= res;
    dr_bank <= ~ab;
  end
  assign rdata_wb = dr_v ? q[dr_bank] : '0;
  assign rvalid_wb = dr_v;
  assign busy = s2_v;
  assign active_bank = ab;
endmodule

// File: tb/tb_rmw_accumulation_buffer.sv
// tb_rmw_accumulation_buffer: directed table and sequence checks of the accumulation buffer
module tb_rmw_accumulation_buffer;
  logic clk = 1'b0, rst_n = 1'b0, switch_banks = 1'b0, acc_en = 1'b0, acc_clear = 1'b0, ren_wb = 1'b0;
  logic [6:0] acc_adr = '0, radr_wb = '0;
  logic [63:0] acc_data = '0, rdata_wb;
  logic rvalid_wb, busy, active_bank;
  logic eab = 1'b0;
  int total = 0, bad = 0;
  typedef struct {
    logic clr;
    logic [6:0] adr;
    logic [63:0] data;
    logic [63:0] exp;
  } vec_t;
  vec_t tv [7];

  rmw_accumulation_buffer dut (
    .clk(clk), .rst_n(rst_n), .switch_banks(switch_banks), .acc_en(acc_en), .acc_clear(acc_clear),
    .acc_adr(acc_adr), .acc_data(acc_data), .ren_wb(ren_wb), .radr_wb(radr_wb), .rdata_wb(rdata_wb),
    .rvalid_wb(rvalid_wb), .busy(busy), .active_bank(active_bank)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pk(int a, int b, int c, int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic acc_op(logic clr, logic [6:0] adr, logic [63:0] data);
    acc_en = 1'b1;
    acc_clear = clr;
    acc_adr = adr;
    acc_data = data;
    step();
    acc_en = 1'b0;
    acc_clear = 1'b0;
  endtask

  task automatic sw();
    switch_banks = 1'b1;
    step();
    switch_banks = 1'b0;
    eab = ~eab;
    chk("active_bank", 64'(active_bank), 64'(eab));
  endtask

  task automatic drain(logic [6:0] adr, logic [63:0] exp, string n);
    ren_wb = 1'b1;
    radr_wb = adr;
    step();
    ren_wb = 1'b0;
    chk({n, "_rvalid"}, 64'(rvalid_wb), 64'd1);
    chk(n, rdata_wb, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    tv[0] = '{1'b1, 7'd10, pk(100, -5, 7, 0), pk(1, 1, 9, 33)};
    tv[1] = '{1'b1, 7'd11, pk(1, 1, 1, 1), pk(3, 4, 5, 6)};
    tv[2] = '{1'b0, 7'd10, pk(-100, 5, 1, 32), pk(1, 1, 9, 33)};
    tv[3] = '{1'b1, 7'd12, pk(-1, -2, -3, -4), pk(0, 0, 0, 0)};
    tv[4] = '{1'b0, 7'd11, pk(2, 3, 4, 5), pk(3, 4, 5, 6)};
    tv[5] = '{1'b0, 7'd12, pk(1, 2, 3, 4), pk(0, 0, 0, 0)};
    tv[6] = '{1'b0, 7'd10, pk(1, 1, 1, 1), pk(1, 1, 9, 33)};
    repeat (3) step();
    chk("rst_rdata", rdata_wb, 64'd0);
    chk("rst_rvalid", 64'(rvalid_wb), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ab", 64'(active_bank), 64'd0);
    rst_n = 1'b1;
    step();
    // accumulate then drain
    acc_op(1'b1, 7'd5, pk(1, 2, 3, 4));
    chk("busy_s2", 64'(busy), 64'd1);
    acc_op(1'b0, 7'd5, pk(10, 10, 10, 10));
    step();
    sw();
    drain(7'd5, pk(11, 12, 13, 14), "basic");
    step();
    chk("idle_rvalid", 64'(rvalid_wb), 64'd0);
    chk("idle_rdata", rdata_wb, 64'd0);
    // same address every cycle
    acc_op(1'b1, 7'd0, pk(1, 0, 0, 0));
    for (int i = 0; i < 7; i++) acc_op(1'b0, 7'd0, pk(1, 0, 0, 0));
    step();
    sw();
    drain(7'd0, pk(8, 0, 0, 0), "fwd_same");
    acc_op(1'b1, 7'd0, pk(1, 0, 0, 0));
    acc_op(1'b1, 7'd1, pk(1, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      acc_op(1'b0, 7'd0, pk(1, 0, 0, 0));
      acc_op(1'b0, 7'd1, pk(1, 0, 0, 0));
    end
    step();
    sw();
    drain(7'd0, pk(4, 0, 0, 0), "fwd_il0");
    drain(7'd1, pk(4, 0, 0, 0), "fwd_il1");
    // bank isolation
    sw();
    for (int k = 0; k < 4; k++) acc_op(1'b1, 7'(k), pk(k, k, k, k));
    step();
    sw();
    for (int k = 0; k < 4; k++) acc_op(1'b1, 7'(k), pk(100 + k, 100 + k, 100 + k, 100 + k));
    step();
    for (int k = 0; k < 4; k++) drain(7'(k), pk(k, k, k, k), "iso_b0");
    sw();
    for (int k = 0; k < 4; k++) drain(7'(k), pk(100 + k, 100 + k, 100 + k, 100 + k), "iso_b1");
    // table batch: mixed lanes, forwarded and SRAM-sourced reads
    for (int i = 0; i < 7; i++) acc_op(tv[i].clr, tv[i].adr, tv[i].data);
    step();
    sw();
    for (int i = 0; i < 7; i++) drain(tv[i].adr, tv[i].exp, $sformatf("tbl%0d", i));
    // overflow
    acc_op(1'b1, 7'd30, pk(32767, -32768, 5, -5));
    acc_op(1'b0, 7'd30, pk(1, -1, -5, 5));
    step();
    sw();
`ifdef ACCUM_SATURATE_EN
    drain(7'd30, pk(32767, -32768, 0, 0), "ovf");
`else
    drain(7'd30, pk(-32768, 32767, 0, 0), "ovf");
`endif
    // switch in the same cycle as an op
    acc_op(1'b1, 7'd2, pk(9, 9, 9, 9));
    step();
    switch_banks = 1'b1;
    acc_op(1'b0, 7'd2, pk(1, 1, 1, 1));
    switch_banks = 1'b0;
    eab = ~eab;
    chk("sw_op_ab", 64'(active_bank), 64'(eab));
    chk("sw_op_busy1", 64'(busy), 64'd1);
    step();
    chk("sw_op_busy0", 64'(busy), 64'd0);
    drain(7'd2, pk(10, 10, 10, 10), "sw_op");
    // reset during S2 suppresses the write
    sw();
    acc_op(1'b1, 7'd20, pk(7, 7, 7, 7));
    step();
    step();
    acc_op(1'b1, 7'd20, pk(55, 55, 55, 55));
    rst_n = 1'b0;
    ren_wb = 1'b1;
    switch_banks = 1'b1;
    step();
    rst_n = 1'b1;
    ren_wb = 1'b0;
    switch_banks = 1'b0;
    eab = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_rvalid", 64'(rvalid_wb), 64'd0);
    chk("mid_rst_rdata", rdata_wb, 64'd0);
    chk("mid_rst_ab", 64'(active_bank), 64'd0);
    step();
    sw();
    drain(7'd20, pk(7, 7, 7, 7), "mid_rst_keep");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
